// File: rtl/ysyx_210544_cache_axi_arbiter.sv
// Arbitrates the I-cache and D-cache line-refill/writeback traffic onto one
// 512-bit line-transfer engine; the winner's request is latched and held for the whole transfer.
module ysyx_210544_cache_axi_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ic_req,
  input  logic [ADDR_W-1:0] i_ic_addr,
  input  logic              i_ic_op,
  input  logic [DATA_W-1:0] i_ic_wdata,
  output logic [DATA_W-1:0] o_ic_rdata,
  output logic              o_ic_ack,
  input  logic              i_dc_req,
  input  logic [ADDR_W-1:0] i_dc_addr,
  input  logic              i_dc_op,
  input  logic [DATA_W-1:0] i_dc_wdata,
  output logic [DATA_W-1:0] o_dc_rdata,
  output logic              o_dc_ack,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_op,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t state, state_nxt;
  logic   grant_sel, last_grant;  // 1 = D-cache, 0 = I-cache
  logic   ic_elig, dc_elig, grant, pick_dc, done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (i_mem_ack) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A requester still holding req in its own ack cycle is masked out.
  always_comb begin
    ic_elig = i_ic_req & ~o_ic_ack;
    dc_elig = i_dc_req & ~o_dc_ack;
    grant   = (state == IDLE) & (ic_elig | dc_elig);
    done    = (state == BUSY) & i_mem_ack;
    if (ic_elig && dc_elig) pick_dc = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
    else                    pick_dc = dc_elig;
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_op    <= 1'b0;
      o_mem_wdata <= '0;
      o_ic_rdata  <= '0;
      o_dc_rdata  <= '0;
      o_ic_ack    <= 1'b0;
      o_dc_ack    <= 1'b0;
      grant_sel   <= 1'b0;
      last_grant  <= 1'b0;
    end else begin
      o_ic_ack <= done & ~grant_sel;
      o_dc_ack <= done & grant_sel;
      if (grant) begin
        o_mem_req   <= 1'b1;
        o_mem_addr  <= pick_dc ? i_dc_addr  : i_ic_addr;
        o_mem_op    <= pick_dc ? i_dc_op    : i_ic_op;
        o_mem_wdata <= pick_dc ? i_dc_wdata : i_ic_wdata;
        grant_sel   <= pick_dc;
        last_grant  <= pick_dc;
      end else if (done) begin
        o_mem_req <= 1'b0;
        if (grant_sel) o_dc_rdata <= i_mem_rdata;
        else           o_ic_rdata <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_210544_cache_axi_arbiter.sv
// Directed bench: a cycle-by-cycle vector table plus hand sequences for
// round-robin order, fixed priority, reset mid-transfer and busy-time input changes.
module tb_ysyx_210544_cache_axi_arbiter;
  localparam int AW = 64, DW = 512;
  localparam logic [AW-1:0] IC_A = 64'h8000_0040, DC_A = 64'h8000_1000;
  localparam logic [DW-1:0] ICW = {16{32'h1111_0000}}, DCW = {16{32'hD0D0_0000}};

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic ic_req = 0, ic_op = 0, dc_req = 0, dc_op = 1, mem_ack = 0;
  logic [AW-1:0] ic_addr = IC_A, dc_addr = DC_A;
  logic [DW-1:0] ic_wdata = ICW, dc_wdata = DCW, mem_rdata = '0;
  logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic ic_ack, dc_ack, mem_req, mem_op, busy;
  logic [AW-1:0] mem_addr;

  // second instance: fixed priority, auto-acking responder
  logic ic_req1 = 0, dc_req1 = 0, m1_ack = 0;
  logic [DW-1:0] ic_rdata1, dc_rdata1, m1_wdata;
  logic ic_ack1, dc_ack1, m1_req, m1_op, busy1;
  logic [AW-1:0] m1_addr;
  int dc1_cnt = 0, ic1_cnt = 0;

  ysyx_210544_cache_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .i_ic_req(ic_req), .i_ic_addr(ic_addr), .i_ic_op(ic_op), .i_ic_wdata(ic_wdata),
    .o_ic_rdata(ic_rdata), .o_ic_ack(ic_ack),
    .i_dc_req(dc_req), .i_dc_addr(dc_addr), .i_dc_op(dc_op), .i_dc_wdata(dc_wdata),
    .o_dc_rdata(dc_rdata), .o_dc_ack(dc_ack),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_op(mem_op), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .o_busy(busy));

  ysyx_210544_cache_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .i_ic_req(ic_req1), .i_ic_addr(ic_addr), .i_ic_op(ic_op), .i_ic_wdata(ic_wdata),
    .o_ic_rdata(ic_rdata1), .o_ic_ack(ic_ack1),
    .i_dc_req(dc_req1), .i_dc_addr(dc_addr), .i_dc_op(dc_op), .i_dc_wdata(dc_wdata),
    .o_dc_rdata(dc_rdata1), .o_dc_ack(dc_ack1),
    .o_mem_req(m1_req), .o_mem_addr(m1_addr), .o_mem_op(m1_op), .o_mem_wdata(m1_wdata),
    .i_mem_rdata('0), .i_mem_ack(m1_ack), .o_busy(busy1));

  initial forever begin
    @(negedge clk);
    m1_ack = m1_req & ~m1_ack;
    if (dc_ack1) dc1_cnt++;
    if (ic_ack1) ic1_cnt++;
  end

  typedef struct {
    logic ic, dc, ack;
    logic mreq, iack, dack, bsy;
    int   sel;  // 0 = nothing latched, 1 = I-cache, 2 = D-cache
  } vec_t;

  vec_t vt[12];
  int nvec = 0, nfail = 0;

  function automatic vec_t mk(logic ic, logic dc, logic ack, logic mreq, logic iack,
                              logic dack, logic bsy, int sel);
    vec_t v;
    v.ic = ic; v.dc = dc; v.ack = ack; v.mreq = mreq;
    v.iack = iack; v.dack = dack; v.bsy = bsy; v.sel = sel;
    return v;
  endfunction

  function automatic logic [DW-1:0] pat(int i);
    return {16{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string nm, input int sel);
    chk({nm, "_addr"}, mem_addr, sel == 2 ? DC_A : sel == 1 ? IC_A : '0);
    chk({nm, "_op"}, mem_op, sel == 2);
    chk({nm, "_wdata"}, mem_wdata, sel == 2 ? DCW : sel == 1 ? ICW : '0);
  endtask

  initial begin
    int w, c0;
    // I read then tie (last grant I -> D), gap, I, and a spurious ack in IDLE
    vt[0]  = mk(1, 0, 0, 1, 0, 0, 1, 1);
    vt[1]  = mk(1, 0, 0, 1, 0, 0, 1, 1);
    vt[2]  = mk(1, 0, 1, 0, 1, 0, 1, 1);
    vt[3]  = mk(1, 0, 0, 0, 0, 0, 0, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    vt[5]  = mk(1, 1, 0, 1, 0, 0, 1, 2);
    vt[6]  = mk(1, 1, 1, 0, 0, 1, 1, 2);
    vt[7]  = mk(1, 1, 0, 0, 0, 0, 0, 2);
    vt[8]  = mk(1, 0, 0, 1, 0, 0, 1, 1);
    vt[9]  = mk(1, 0, 1, 0, 1, 0, 1, 1);
    vt[10] = mk(1, 0, 0, 0, 0, 0, 0, 1);
    vt[11] = mk(0, 0, 1, 0, 0, 0, 0, 1);

    step; step;
    rst = 0;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {ic_ack, dc_ack}, 0);
    chk("rst_rdata", {ic_rdata, dc_rdata}, 0);
    chk_sel("rst", 0);

    // Round robin from reset: D,I,D,I,D,I; fixed-priority instance runs alongside
    c0 = dc1_cnt;
    ic_req = 1; dc_req = 1; ic_req1 = 1; dc_req1 = 1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!mem_req && w < 8) begin step; w++; end
      chk("rr_req", mem_req, 1);
      if (k > 0) chk("rr_gap", w >= 2, 1);
      chk_sel("rr", (k % 2 == 0) ? 2 : 1);
      mem_ack = 1; step; mem_ack = 0;
      chk("rr_dack", dc_ack, k % 2 == 0);
      chk("rr_iack", ic_ack, k % 2 == 1);
    end
    ic_req = 0; dc_req = 0; ic_req1 = 0; dc_req1 = 0;
    step; step; step; step;
    chk("fp_ic_never", ic1_cnt, 0);
    chk("fp_dc_only", (dc1_cnt - c0) >= 3, 1);

    for (int i = 0; i < 12; i++) begin
      ic_req = vt[i].ic; dc_req = vt[i].dc; mem_ack = vt[i].ack; mem_rdata = pat(i);
      step;
      chk($sformatf("v%0d_mem_req", i), mem_req, vt[i].mreq);
      chk($sformatf("v%0d_ic_ack", i), ic_ack, vt[i].iack);
      chk($sformatf("v%0d_dc_ack", i), dc_ack, vt[i].dack);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      chk_sel($sformatf("v%0d", i), vt[i].sel);
    end
    mem_ack = 0;
    chk("ic_rdata_hold", ic_rdata, pat(9));
    chk("dc_rdata_hold", dc_rdata, pat(6));

    // Reset while BUSY, then D-first tie again
    ic_req = 1; dc_req = 1;
    step;
    chk_sel("pre_rst", 2);
    rst = 1; step; rst = 0;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdata", ic_rdata, 0);
    chk_sel("mid_rst", 0);
    step;
    chk("post_rst_req", mem_req, 1);
    chk_sel("post_rst", 2);
    mem_rdata = pat(77); mem_ack = 1; step; mem_ack = 0;
    chk("post_rst_dack", {ic_ack, dc_ack}, 2'b01);
    chk("post_rst_rdata", dc_rdata, pat(77));
    dc_req = 0; step;
    chk("gap_req", mem_req, 0);
    step;
    chk_sel("i_after_d", 1);

    // Inputs changing during BUSY are ignored; D waits until after the gap
    ic_addr = 64'hDEAD_0000; dc_req = 1;
    step; step;
    chk("busy_hold_req", mem_req, 1);
    chk_sel("busy_hold", 1);
    mem_ack = 1; step; mem_ack = 0;
    chk("busy_iack", {ic_ack, dc_ack}, 2'b10);
    step;
    chk("mask_no_grant", mem_req, 0);
    ic_req = 0; ic_addr = IC_A;
    step;
    chk("d_after_gap_req", mem_req, 1);
    chk_sel("d_after_gap", 2);
    mem_ack = 1; step; mem_ack = 0; dc_req = 0;
    step; step;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
